// File: rtl/muldiv_seq_if.sv
// Operation, MTHI/MTLO and result signals between the control unit and muldiv_seq.
interface muldiv_seq_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 2
);
  logic                  i_start;
  logic [OP_WIDTH-1:0]   i_op;
  logic [DATA_WIDTH-1:0] i_op_a;
  logic [DATA_WIDTH-1:0] i_op_b;
  logic                  i_hi_we;
  logic                  i_lo_we;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_div_zero;
  logic [DATA_WIDTH-1:0] o_hi;
  logic [DATA_WIDTH-1:0] o_lo;

  // Control-unit side.
  modport master (
    output i_start, i_op, i_op_a, i_op_b, i_hi_we, i_lo_we, i_wdata,
    input  o_busy, o_done, o_div_zero, o_hi, o_lo
  );

  // Execution-unit side.
  modport slave (
    input  i_start, i_op, i_op_a, i_op_b, i_hi_we, i_lo_we, i_wdata,
    output o_busy, o_done, o_div_zero, o_hi, o_lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, owning the HI/LO registers.
module muldiv_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  muldiv_seq_if.slave bus
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               is_signed_q, is_signed_d;
  logic               sign_res_q, sign_res_d;
  logic               sign_rem_q, sign_rem_d;
  logic               div_zero_q, div_zero_d;
  logic [W-1:0]       a_mag_q, a_mag_d;
  logic [W-1:0]       b_mag_q, b_mag_d;
  logic [W-1:0]       raw_a_q, raw_a_d;
  logic [2*W-1:0]     acc_q, acc_d;
  logic [W-1:0]       rem_q, rem_d;
  logic [W-1:0]       quo_q, quo_d;
  logic [W-1:0]       hi_q, hi_d;
  logic [W-1:0]       lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic [OP_WIDTH-1:0] op_c;
  logic                op_signed_c;
  logic [W-1:0]        a_abs_c, b_abs_c;
  logic [W:0]          mul_sum_c;
  logic [W:0]          div_shift_c;
  logic [W:0]          div_diff_c;
  logic                div_ge_c;
  logic [2*W-1:0]      prod_fix_c;
  logic [W-1:0]        quo_fix_c, rem_fix_c;

  assign op_c = bus.i_op;

  // Operand magnitudes, per-iteration datapath and final sign fix-up.
  always_comb begin
    op_signed_c = ~op_c[0];
    a_abs_c     = (op_signed_c && bus.i_op_a[W-1]) ? W'(-bus.i_op_a) : bus.i_op_a;
    b_abs_c     = (op_signed_c && bus.i_op_b[W-1]) ? W'(-bus.i_op_b) : bus.i_op_b;

    // Shift-add: add multiplicand into the upper half when the current multiplier bit is set.
    mul_sum_c   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_mag_q} : {(W+1){1'b0}});

    // Restoring step: bring in the next dividend bit and try subtracting the divisor.
    div_shift_c = {rem_q, quo_q[W-1]};
    div_ge_c    = (div_shift_c >= {1'b0, b_mag_q});
    div_diff_c  = div_shift_c - {1'b0, b_mag_q};

    prod_fix_c  = (is_signed_q && sign_res_q) ? (2*W)'(-acc_q) : acc_q;
    quo_fix_c   = (is_signed_q && sign_res_q) ? W'(-quo_q) : quo_q;
    rem_fix_c   = (is_signed_q && sign_rem_q) ? W'(-rem_q) : rem_q;
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    sign_res_d  = sign_res_q;
    sign_rem_d  = sign_rem_q;
    div_zero_d  = div_zero_q;
    a_mag_d     = a_mag_q;
    b_mag_d     = b_mag_q;
    raw_a_d     = raw_a_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    dz_d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_hi_we) hi_d = bus.i_wdata;
        if (bus.i_lo_we) lo_d = bus.i_wdata;
        if (bus.i_start) begin
          state_d     = ST_CALC;
          cnt_d       = '0;
          is_div_d    = op_c[1];
          is_signed_d = op_signed_c;
          sign_res_d  = bus.i_op_a[W-1] ^ bus.i_op_b[W-1];
          sign_rem_d  = bus.i_op_a[W-1];
          div_zero_d  = op_c[1] && (bus.i_op_b == '0);
          a_mag_d     = a_abs_c;
          b_mag_d     = b_abs_c;
          raw_a_d     = bus.i_op_a;
          acc_d       = {{W{1'b0}}, b_abs_c};
          rem_d       = '0;
          quo_d       = a_abs_c;
        end
      end

      ST_CALC: begin
        if (is_div_q) begin
          rem_d = W'(div_ge_c ? div_diff_c : div_shift_c);
          quo_d = {quo_q[W-2:0], div_ge_c};
        end else begin
          acc_d = {mul_sum_c, acc_q[W-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix_c[2*W-1:W];
          lo_d = prod_fix_c[W-1:0];
        end else if (div_zero_q) begin
          hi_d = raw_a_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else begin
          hi_d = rem_fix_c;
          lo_d = quo_fix_c;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      sign_res_q  <= 1'b0;
      sign_rem_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      a_mag_q     <= '0;
      b_mag_q     <= '0;
      raw_a_q     <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      sign_res_q  <= sign_res_d;
      sign_rem_q  <= sign_rem_d;
      div_zero_q  <= div_zero_d;
      a_mag_q     <= a_mag_d;
      b_mag_q     <= b_mag_d;
      raw_a_q     <= raw_a_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      done_q      <= done_d;
      dz_q        <= dz_d;
    end
  end

  // Outputs: registered, busy decoded from the state register.
  assign bus.o_busy     = (state_q != ST_IDLE);
  assign bus.o_done     = done_q;
  assign bus.o_div_zero = dz_q;
  assign bus.o_hi       = hi_q;
  assign bus.o_lo       = lo_q;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Sequential multiply/divide unit with HI/LO registers for the MIPS core. It executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle, beside the single-cycle ALU. It holds the architectural HI/LO state that MFHI/MFLO read and MTHI/MTLO write. The main control unit stalls the pipeline on `o_busy` and issues at most one operation at a time.

## Interface
- `DATA_WIDTH`, default 32: operand, HI and LO width.
- `OP_WIDTH`, default 2: operation code width.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  launch request; sampled only in IDLE.
- `i_op`  in  OP_WIDTH  operation, equal to function[1:0]: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `i_op_a`  in  DATA_WIDTH  rs operand: multiplicand or dividend.
- `i_op_b`  in  DATA_WIDTH  rt operand: multiplier or divisor.
- `i_hi_we`  in  1  MTHI write enable.
- `i_lo_we`  in  1  MTLO write enable.
- `i_wdata`  in  DATA_WIDTH  MTHI/MTLO data.
- `o_busy`  out  1  high whenever state ≠ IDLE.
- `o_done`  out  1  registered one-cycle pulse when a result is committed to HI/LO.
- `o_div_zero`  out  1  registered one-cycle pulse, coincident with `o_done`, for DIV/DIVU with divisor 0.
- `o_hi`  out  DATA_WIDTH  architectural HI.
- `o_lo`  out  DATA_WIDTH  architectural LO.

## Operation
- **Reset values:** state IDLE, `o_hi`=0, `o_lo`=0, `o_busy`=0, `o_done`=0, `o_div_zero`=0, iteration counter 0, working registers 0.
- **States:**
  - IDLE → CALC when `i_start`=1.
  - CALC → CALC while the counter < DATA_WIDTH-1, incrementing the counter each cycle.
  - CALC → FIX at the last iteration.
  - FIX → IDLE unconditionally.
- **Capture (IDLE edge with `i_start`):**
  - Latch `i_op`.
  - For signed ops, latch |`i_op_a`| and |`i_op_b`| as unsigned DATA_WIDTH values; -2^(W-1) maps to 2^(W-1). Unsigned ops latch the operands unchanged.
  - Latch the sign flags: result sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Latch the divide-by-zero flag (`i_op_b`==0, DIV/DIVU only).
- **CALC, multiply:** shift-add on a 2·DATA_WIDTH accumulator, one multiplier bit per cycle, LSB first.
- **CALC, divide:** restoring division, one quotient bit per cycle, MSB first. Remainder is DATA_WIDTH+1 bits internally.
- **FIX:**
  - Signed multiply: negate the 2W product if the result sign is set.
  - Signed divide: negate the quotient if the result sign is set; negate the remainder if the remainder sign is set.
  - Multiply: HI ← product[2W-1:W], LO ← product[W-1:0].
  - Divide: HI ← remainder, LO ← quotient.
  - Divide by zero, both signednesses: HI ← captured raw `i_op_a`, LO ← all ones. Latency is the same as a normal divide.
  - Assert `o_done`, and `o_div_zero` if applicable.
- **Signed overflow:** DIV of -2^(W-1) by -1 gives LO=0x80000000, HI=0 (wraps). No flag is raised.
- **HI/LO visibility:** `o_hi`/`o_lo` hold their previous values throughout CALC/FIX. Intermediate values are never visible.
- **MTHI/MTLO:**
  - `i_hi_we`/`i_lo_we` write HI/LO only when state = IDLE.
  - They are ignored while busy; the pipeline must stall on `o_busy`.
  - If `i_start` and a write occur on the same IDLE edge, both are honoured. The write lands now and is overwritten at FIX.
- **`i_start` while busy:** ignored, not queued. `i_op` and the operands are don't-care outside the capture edge.
- **Reset mid-operation:** returns to IDLE immediately with reset values. No `o_done` is generated, and the previous HI/LO are lost (cleared to 0).

## Timing
- Capture at edge 0; `o_busy`=1 from edge 0.
- CALC iterations on edges 1..DATA_WIDTH.
- FIX commits on edge DATA_WIDTH+1. After that edge, `o_hi`/`o_lo` hold the result, `o_done`=1 for exactly one cycle, and `o_busy`=0.
- `o_busy` is high for exactly DATA_WIDTH+1 cycles per operation (33 at default).
- A new `i_start` is accepted in the same cycle `o_done` is high, so operations can run back-to-back every DATA_WIDTH+2 cycles.
- MTHI/MTLO are visible on `o_hi`/`o_lo` one edge after the write.
- `o_busy` is a decode of the state register only; all outputs are glitch-free registered or state-decoded.

## Test plan
- **MULTU:** MULTU 0xFFFFFFFF×0xFFFFFFFF → `o_done` exactly 33 cycles after start, HI=0xFFFFFFFE, LO=0x00000001, `o_busy` high for 33 cycles.
- **Signed ops:**
  - MULT -3×5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/2 → LO=3, HI=1.
- **Edge divisions:**
  - DIVU 7/0 → HI=7, LO=0xFFFFFFFF, `o_div_zero` and `o_done` pulse together.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0, no `o_div_zero`.
- **HI/LO holding and MT writes:**
  - MTHI 0x1234 in IDLE → `o_hi`=0x1234 next cycle.
  - Start MULTU 2×3, then pulse `i_lo_we` and `i_start` mid-CALC → both ignored, `o_hi`=0x1234 holds until FIX, then HI=0, LO=6.
- **Reset mid-operation:** start DIVU, drop `i_rst_n` at cycle 10 → `o_busy`, `o_hi`, `o_lo` go 0 asynchronously, no `o_done`. After release, a fresh MULTU 4×4 gives LO=16.
- **Back-to-back:** assert `i_start` (MULT 2×-1) in the `o_done` cycle of a prior op → accepted, second `o_done` 33 cycles later, HI=0xFFFFFFFF, LO=0xFFFFFFFE.
